// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-side signals of the shared memory port arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              cpu_stall;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        output cpu_stall,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        input  cpu_stall,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: loader > data > fetch, with a starvation counter that
// lets fetch overtake data, and 1-cycle read return routed to the issuing owner.
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_F    = 2'd3;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

    logic              w_ld_win;
    logic              w_d_win;
    logic              w_f_win;
    logic              w_f_force;
    logic [ADDR_W-1:0] w_f_word;
    logic              w_unused_f_lsb;

    logic [3:0]        r_starve;
    logic [1:0]        r_owner;
    logic [DATA_W-1:0] r_ld_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_f_rdata;

    // Fetch carries a byte address; the RAM is word addressed.
    assign w_f_word       = {1'b0, bus.f_addr[ADDR_W-1:1]};
    assign w_unused_f_lsb = bus.f_addr[0];

    assign w_f_force = bus.f_req && (r_starve == LIMIT);
    assign w_ld_win  = reset && bus.ld_req;
    assign w_d_win   = reset && !bus.ld_req && bus.d_req && !w_f_force;
    assign w_f_win   = reset && !bus.ld_req && bus.f_req && (!bus.d_req || w_f_force);

    assign bus.ld_gnt    = w_ld_win;
    assign bus.d_gnt     = w_d_win;
    assign bus.f_gnt     = w_f_win;
    assign bus.cpu_stall = reset && ((bus.d_req && !w_d_win) || (bus.f_req && !w_f_win));

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (w_ld_win) begin
            bus.ram_addr  = bus.ld_addr;
            bus.ram_we    = bus.ld_we;
            bus.ram_wdata = bus.ld_wdata;
        end else if (w_d_win) begin
            bus.ram_addr  = bus.d_addr;
            bus.ram_we    = bus.d_we;
            bus.ram_wdata = bus.d_wdata;
        end else if (w_f_win) begin
            bus.ram_addr  = w_f_word;
        end
    end

    // A loader win leaves the count alone so preemption neither helps nor hurts fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (!bus.f_req || w_f_win) begin
            r_starve <= '0;
        end else if (w_d_win && (r_starve != LIMIT)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner <= OWN_NONE;
        end else if (w_ld_win && !bus.ld_we) begin
            r_owner <= OWN_LD;
        end else if (w_d_win && !bus.d_we) begin
            r_owner <= OWN_D;
        end else if (w_f_win) begin
            r_owner <= OWN_F;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ld_rdata <= '0;
            r_d_rdata  <= '0;
            r_f_rdata  <= '0;
        end else begin
            if (r_owner == OWN_LD) r_ld_rdata <= bus.ram_rdata;
            if (r_owner == OWN_D)  r_d_rdata  <= bus.ram_rdata;
            if (r_owner == OWN_F)  r_f_rdata  <= bus.ram_rdata;
        end
    end

    // Owner sees RAM data directly in its rvalid cycle, the held copy otherwise.
    assign bus.ld_rvalid = (r_owner == OWN_LD);
    assign bus.d_rvalid  = (r_owner == OWN_D);
    assign bus.f_rvalid  = (r_owner == OWN_F);
    assign bus.ld_rdata  = bus.ld_rvalid ? bus.ram_rdata : r_ld_rdata;
    assign bus.d_rdata   = bus.d_rvalid  ? bus.ram_rdata : r_d_rdata;
    assign bus.f_rdata   = bus.f_rvalid  ? bus.ram_rdata : r_f_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, shadow-memory scoreboard for read
// returns, and directed grant/priority/reset sequences.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] ram    [256];
    logic [15:0] shadow [256];
    logic [17:0] sb_q   [$];
    logic [1:0]  eo;
    logic [15:0] ed;
    logic [17:0] ent;
    logic [7:0]  fw;

    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: read returns checked against the shadow, then new grants queued.
    always @(negedge clk) begin
        eo = 2'd0;
        ed = 16'h0;
        if (!reset) sb_q.delete();
        else if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            eo  = ent[17:16];
            ed  = ent[15:0];
        end
        chk("ld_rvalid", 32'(bus.ld_rvalid), 32'(eo == 2'd1));
        chk("d_rvalid",  32'(bus.d_rvalid),  32'(eo == 2'd2));
        chk("f_rvalid",  32'(bus.f_rvalid),  32'(eo == 2'd3));
        if (eo == 2'd1) chk("ld_rdata", 32'(bus.ld_rdata), 32'(ed));
        if (eo == 2'd2) chk("d_rdata",  32'(bus.d_rdata),  32'(ed));
        if (eo == 2'd3) chk("f_rdata",  32'(bus.f_rdata),  32'(ed));
        if (reset) begin
            fw = {1'b0, bus.f_addr[7:1]};
            if (bus.ld_gnt && bus.ld_we) shadow[bus.ld_addr] = bus.ld_wdata;
            if (bus.d_gnt && bus.d_we)   shadow[bus.d_addr]  = bus.d_wdata;
            if (bus.ld_gnt && !bus.ld_we) sb_q.push_back({2'd1, shadow[bus.ld_addr]});
            if (bus.d_gnt && !bus.d_we)   sb_q.push_back({2'd2, shadow[bus.d_addr]});
            if (bus.f_gnt)                sb_q.push_back({2'd3, shadow[fw]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
        bus.d_req  = 0; bus.d_we  = 0; bus.d_addr  = 0; bus.d_wdata  = 0;
        bus.f_req  = 0; bus.f_addr = 0;
    endtask

    task automatic chk_gnt(input string tag, input logic l, input logic d, input logic f, input logic st);
        chk({tag, "_ld_gnt"}, 32'(bus.ld_gnt), 32'(l));
        chk({tag, "_d_gnt"},  32'(bus.d_gnt),  32'(d));
        chk({tag, "_f_gnt"},  32'(bus.f_gnt),  32'(f));
        chk({tag, "_stall"},  32'(bus.cpu_stall), 32'(st));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 16'h0;
            shadow[i] = 16'h0;
        end
        ram[8'h05]    = 16'h1234;
        shadow[8'h05] = 16'h1234;
        bus.ram_rdata = 16'h0;
        idle();
        reset = 1'b0;

        // Reset with everyone requesting
        bus.ld_req = 1; bus.d_req = 1; bus.d_addr = 8'h20; bus.f_req = 1; bus.f_addr = 8'h0A;
        repeat (3) begin
            @(negedge clk);
            chk_gnt("rst", 0, 0, 0, 0);
            chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        end
        step();
        reset = 1'b1;
        @(negedge clk);
        chk_gnt("rel", 1, 0, 0, 1);
        step();
        idle();

        // Single fetch reads, even and odd byte address
        bus.f_req = 1; bus.f_addr = 8'h0A;
        @(negedge clk);
        chk_gnt("f_rd", 0, 0, 1, 0);
        chk("f_rd_addr", 32'(bus.ram_addr), 32'h05);
        chk("f_rd_we", 32'(bus.ram_we), 32'd0);
        step();
        bus.f_addr = 8'h0B;
        @(negedge clk);
        chk("f_odd_addr", 32'(bus.ram_addr), 32'h05);
        step();
        idle();
        @(negedge clk);
        step();

        // Data write then read-after-write
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 16'hBEEF;
        @(negedge clk);
        chk_gnt("d_wr", 0, 1, 0, 0);
        chk("d_wr_we",    32'(bus.ram_we),    32'd1);
        chk("d_wr_addr",  32'(bus.ram_addr),  32'h20);
        chk("d_wr_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        step();
        bus.d_we = 0;
        @(negedge clk);
        chk_gnt("d_rd", 0, 1, 0, 0);
        chk("d_rd_we", 32'(bus.ram_we), 32'd0);
        step();
        idle();
        @(negedge clk);
        step();
        @(negedge clk);
        chk("d_hold_rdata", 32'(bus.d_rdata), 32'hBEEF);
        step();

        // Starvation: d wins four times, then fetch is forced ahead
        bus.d_req = 1; bus.d_addr = 8'h20;
        bus.f_req = 1; bus.f_addr = 8'h0A;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_gnt($sformatf("starve%0d", i), 0, !(i == 4 || i == 9), (i == 4 || i == 9), 1);
            step();
        end
        // Count is now 2; loader preempts and must not disturb it
        bus.ld_req = 1; bus.ld_addr = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_gnt($sformatf("ld_pre%0d", i), 1, 0, 0, 1);
            chk("ld_pre_addr", 32'(bus.ram_addr), 32'h05);
            step();
        end
        bus.ld_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_gnt($sformatf("post_ld%0d", i), 0, (i != 2), (i == 2), 1);
            step();
        end
        idle();
        @(negedge clk);
        step();

        // Reset arriving at the issue edge of a fetch read
        bus.f_req = 1; bus.f_addr = 8'h0A;
        @(negedge clk);
        chk_gnt("mid_rst", 0, 0, 1, 0);
        #1;
        reset = 1'b0;
        bus.f_req = 0;
        step();
        @(negedge clk);
        chk("mid_rst_f_rdata",  32'(bus.f_rdata),  32'd0);
        chk("mid_rst_d_rdata",  32'(bus.d_rdata),  32'd0);
        chk("mid_rst_ld_rdata", 32'(bus.ld_rdata), 32'd0);
        step();
        reset = 1'b1;
        bus.d_req = 1; bus.d_addr = 8'h20;
        @(negedge clk);
        chk_gnt("after_rst", 0, 1, 0, 0);
        step();
        idle();
        repeat (3) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
